cy_tx_scheduler: RTL and testbench
==================================

// Module: cy_tx_scheduler
// PURPOSE
//  Shares the Cypress FX2 IN-endpoint write path between all message sources (SPI and UART receivers).
//  - Picks one source that holds a complete message, round-robin.
//  - Sends a header word, then the message payload words, then ends the packet.
//  - Sits between the per-source RX FIFOs and the slave-FIFO pin driver; pacing follows FX2 FLAG_FULL.
// PARAMETERS
//  N_SRC   6   number of sources; must match `NUM_SOURCES
//  LEN_W   8   message length field width, in 16-bit words
//  ID_W    8   source-id field width in the header word
// PORTS
//  CLK           in   1          system clock (ifclk domain)
//  RST           in   1          synchronous reset, active-high
//  GOT_FULL_MSG  in   N_SRC      per-source: at least one complete message is buffered
//  MSG_LEN_BUS   in   N_SRC*8    per-source payload length of the head message, in words
//  FIFO_Q_BUS    in   N_SRC*16   per-source show-ahead FIFO output; valid while the message is unread
//  FLAG_FULL     in   1          FX2 FLAGB, active-low: 0 = IN endpoint full
//  HOLD          in   1          OUT-direction transfer pending; blocks new grants
//  RD_REQ        out  N_SRC      per-source FIFO read acknowledge, one-hot
//  MSG_START     out  N_SRC      one-cycle pulse to the granted source at grant
//  TX_DATA       out  16         word to drive on FD, big-endian
//  TX_WR         out  1          write strobe; the pin driver converts it to SLWR
//  PKTEND_REQ    out  1          one-cycle packet-commit request
//  BUSY          out  1          high from grant until the end of END
//  GRANT_ID      out  4          index of the granted source; held after the transfer
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant = N_SRC-1, so source 0 wins first.
//  States: IDLE -> ARB -> HDR -> PAY -> END -> IDLE.
//  IDLE
//   - Go to ARB when |GOT_FULL_MSG and !HOLD.
//   - HOLD is sampled only in IDLE and ARB; once HDR is entered, the message always completes.
//  ARB (one cycle)
//   - Grant g = first set bit of GOT_FULL_MSG, searching from last_grant+1 with wrap at N_SRC-1.
//   - Latch len = MSG_LEN_BUS[g]; set last_grant = g and GRANT_ID = g; pulse MSG_START[g].
//   - If HOLD rose or GOT_FULL_MSG cleared, return to IDLE without granting.
//  HDR
//   - TX_DATA = {g[ID_W-1:0], len}; TX_WR = 1 only in a cycle with FLAG_FULL = 1, else wait.
//   - After the write: go to PAY if len != 0, otherwise to END.
//  PAY
//   - TX_DATA = FIFO_Q_BUS[g]; TX_WR = RD_REQ[g] = FLAG_FULL; count increments on each write.
//   - Leave for END after the write where count == len-1.
//   - FLAG_FULL low mid-payload: TX_WR = 0 and RD_REQ = 0; data and count frozen.
//  END
//   - Pulse PKTEND_REQ for one cycle once FLAG_FULL = 1, then go to IDLE; BUSY drops in that cycle.
//  Throughput and latency
//   - Best case: grant to first header write is 1 cycle.
//   - A message of L words occupies L+3 cycles: ARB + HDR + L + END.
//  Width rules
//   - count is LEN_W bits; len = 255 is legal; no wrap occurs because exit happens at len-1.
//  Reset during HDR, PAY or END: abort immediately, with no PKTEND.
//  TX_WR and RD_REQ are never high in the same cycle as FLAG_FULL = 0.
//  The round-robin pointer advances only on a real grant.
// STRUCTURE
//  Shared constants in defines.v: `NUM_SOURCES, state encodings, header field positions.
//  Sub-module rr_arbiter (N_SRC): request vector + last_grant -> one-hot grant + index; purely combinational.
//  The datapath muxes FIFO_Q_BUS and MSG_LEN_BUS by the registered g.
// TESTING
//  1. Source 2 only, len = 3, FLAG_FULL = 1.
//     Expect MSG_START[2] one cycle; TX_DATA 0x0203, then 3 words with RD_REQ[2]; one PKTEND_REQ; 6 cycles total.
//  2. Sources 0, 1, 4 all full, back-to-back messages.
//     Expect grant order 0, 1, 4, 0; GRANT_ID matches each header's upper byte.
//  3. len = 0 on source 5.
//     Expect header 0x0500, no RD_REQ, PKTEND_REQ on the next writable cycle.
//  4. FLAG_FULL = 0 for 4 cycles during the 2nd payload word.
//     Expect no TX_WR and no RD_REQ while low; the word resumes unchanged; the count stays correct.
//  5. HOLD = 1 while requests are pending.
//     Expect no grant; with HOLD asserted mid-PAY, the message still completes with PKTEND.
//  6. RST asserted mid-PAY.
//     Expect all outputs 0 the next cycle, no PKTEND; the next grant goes to the lowest pending source from 0.

Source files
------------

// File: rtl/cy_tx_scheduler_pkg.sv
// Shared definitions for the FX2 IN-endpoint transmit scheduler.
//   NUM_SOURCES : default number of message sources feeding the scheduler
//   DATA_W      : FX2 slave-FIFO data bus width
//   GID_W       : width of the exported grant index
//   tx_state_e  : scheduler FSM encoding
package cy_tx_scheduler_pkg;

  localparam int NUM_SOURCES = 6;
  localparam int DATA_W      = 16;
  localparam int GID_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_END  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/cy_tx_scheduler_rr_arb.sv
// Combinational round-robin picker.
//   req       : per-source request vector
//   last      : index granted most recently
//   grant_oh  : one-hot grant, zero when nothing is requested
//   grant_idx : index of the granted source
//   grant_vld : at least one request present
module cy_tx_scheduler_rr_arb #(
  parameter int N_SRC = 6,
  parameter int IDX_W = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_SRC-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Scan from the farthest candidate back to last+1 so the nearest
  // requester after last is the final (winning) assignment.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = N_SRC; i >= 1; i--) begin : scan
      int pos;
      logic [IDX_W-1:0] pos_v;
      pos = int'(last) + i;
      if (pos >= N_SRC) pos = pos - N_SRC;
      pos_v = IDX_W'(pos);
      if (req[pos_v]) begin
        grant_idx = pos_v;
        grant_vld = 1'b1;
      end
    end
    grant_oh = grant_vld ? (N_SRC'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cy_tx_scheduler.sv
// Shares the FX2 IN-endpoint write path between the SPI/UART message sources.
// Picks a source holding a complete message (round-robin), writes a header
// word {id, len}, streams len payload words from the source FIFO, then
// requests PKTEND. Writes are paced by flag_full (active-low full).
//   clk, rst          : clock, synchronous active-high reset
//   got_full_msg      : per-source complete-message flag
//   msg_len_bus       : per-source head-message length (words)
//   fifo_q_bus        : per-source show-ahead FIFO output
//   flag_full         : 1 = endpoint writable
//   hold              : blocks new grants
//   rd_req            : per-source FIFO read acknowledge
//   msg_start         : grant pulse to the selected source
//   tx_data, tx_wr    : word and write strobe to the pin driver
//   pktend_req        : packet commit request
//   busy              : transfer in progress
//   grant_id          : index of the last granted source
module cy_tx_scheduler
  import cy_tx_scheduler_pkg::*;
#(
  parameter int N_SRC = NUM_SOURCES,
  parameter int LEN_W = 8,
  parameter int ID_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        got_full_msg,
  input  logic [N_SRC*LEN_W-1:0]  msg_len_bus,
  input  logic [N_SRC*DATA_W-1:0] fifo_q_bus,
  input  logic                    flag_full,
  input  logic                    hold,
  output logic [N_SRC-1:0]        rd_req,
  output logic [N_SRC-1:0]        msg_start,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_wr,
  output logic                    pktend_req,
  output logic                    busy,
  output logic [GID_W-1:0]        grant_id
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  tx_state_e        state_q, state_d;
  logic [IDX_W-1:0] g_q, last_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [GID_W-1:0] grant_id_q;

  logic [LEN_W-1:0]  len_arr [N_SRC];
  logic [DATA_W-1:0] q_arr   [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign len_arr[i] = msg_len_bus[i*LEN_W +: LEN_W];
    assign q_arr[i]   = fifo_q_bus[i*DATA_W +: DATA_W];
  end

  logic [N_SRC-1:0] arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;

  cy_tx_scheduler_rr_arb #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_arb (
    .req       (got_full_msg),
    .last      (last_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  logic             arb_take, pay_wr;
  logic [N_SRC-1:0] g_oh;

  // A grant is only real if the request is still there and hold has not risen.
  assign arb_take = (state_q == ST_ARB) && !hold && arb_vld;
  assign pay_wr   = (state_q == ST_PAY) && flag_full;
  assign g_oh     = N_SRC'(1) << g_q;
  assign grant_id = grant_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= IDX_W'(N_SRC - 1);
      g_q        <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (arb_take) begin
        g_q        <= arb_idx;
        last_q     <= arb_idx;
        len_q      <= len_arr[arb_idx];
        grant_id_q <= GID_W'(arb_idx);
        cnt_q      <= '0;
      end else if (pay_wr) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_req     = '0;
    msg_start  = '0;
    tx_data    = '0;
    tx_wr      = 1'b0;
    pktend_req = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|got_full_msg) && !hold) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (arb_take) begin
          msg_start = arb_oh;
          busy      = 1'b1;
          state_d   = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        busy    = 1'b1;
        tx_data = {ID_W'(g_q), len_q};
        tx_wr   = flag_full;
        if (flag_full) state_d = (len_q != '0) ? ST_PAY : ST_END;
      end
      ST_PAY: begin
        busy    = 1'b1;
        tx_data = q_arr[g_q];
        tx_wr   = flag_full;
        rd_req  = flag_full ? g_oh : '0;
        // Exit on the last word so a 255-word message never wraps cnt_q.
        if (flag_full && (cnt_q == len_q - LEN_W'(1))) state_d = ST_END;
      end
      ST_END: begin
        busy       = 1'b1;
        pktend_req = flag_full;
        if (flag_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cy_tx_scheduler.sv
module tb_cy_tx_scheduler;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  got_full_msg;
  logic [N*8-1:0]  msg_len_bus;
  logic [N*16-1:0] fifo_q_bus;
  logic          flag_full;
  logic          hold;
  logic [N-1:0]  rd_req;
  logic [N-1:0]  msg_start;
  logic [15:0]   tx_data;
  logic          tx_wr;
  logic          pktend_req;
  logic          busy;
  logic [3:0]    grant_id;

  cy_tx_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .got_full_msg (got_full_msg),
    .msg_len_bus  (msg_len_bus),
    .fifo_q_bus   (fifo_q_bus),
    .flag_full    (flag_full),
    .hold         (hold),
    .rd_req       (rd_req),
    .msg_start    (msg_start),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .pktend_req   (pktend_req),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  data;
    logic [N-1:0] rd;
    bit           is_hdr;
    bit           is_end;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];

  int tests = 0;
  int fails = 0;

  int          pend   [N];
  int          widx   [N];
  int          mno    [N];
  int          issued [N];
  logic [7:0]  len_cfg[N];

  int cyc = 0;
  int start_cyc, end_cyc, hdr_cyc;
  bit seen_start;

  logic          o_wr, o_pk, o_busy;
  logic [N-1:0]  o_rd, o_ms;
  logic [15:0]   o_data;
  logic [3:0]    o_gid;

  function automatic logic [15:0] pw(int s, int m, int k);
    return {s[3:0], m[3:0], k[7:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_buses();
    logic [N*8-1:0]  lb;
    logic [N*16-1:0] qb;
    lb = '0;
    qb = '0;
    for (int s = N - 1; s >= 0; s--) begin
      lb = {lb[N*8-9:0], len_cfg[s]};
      qb = {qb[N*16-17:0], pw(s, mno[s], widx[s])};
      got_full_msg[s] = (pend[s] > 0);
    end
    msg_len_bus = lb;
    fifo_q_bus  = qb;
  endtask

  task automatic model_clear();
    for (int s = 0; s < N; s++) begin
      pend[s] = 0; widx[s] = 0; mno[s] = 0; issued[s] = 0; len_cfg[s] = 8'd0;
    end
    exp_q.delete();
    gnt_q.delete();
    drive_buses();
  endtask

  // Queue a message on source s and record what the scheduler must emit for it.
  task automatic load(int s, int len);
    exp_t e;
    len_cfg[s] = len[7:0];
    issued[s]++;
    gnt_q.push_back(s);
    e.data = {s[7:0], len[7:0]}; e.rd = '0; e.is_hdr = 1; e.is_end = 0;
    exp_q.push_back(e);
    for (int k = 0; k < len; k++) begin
      e.data = pw(s, issued[s], k); e.rd = N'(1) << s; e.is_hdr = 0; e.is_end = 0;
      exp_q.push_back(e);
    end
    e.data = '0; e.rd = '0; e.is_hdr = 0; e.is_end = 1;
    exp_q.push_back(e);
    pend[s]++;
    drive_buses();
  endtask

  task automatic tick();
    exp_t e;
    int   g;
    @(negedge clk);
    cyc++;
    o_wr = tx_wr; o_pk = pktend_req; o_busy = busy; o_rd = rd_req;
    o_ms = msg_start; o_data = tx_data; o_gid = grant_id;
    if (o_wr === 1'b1 || o_rd !== '0 || o_pk === 1'b1)
      chk("write_while_full", {31'd0, flag_full}, 32'd1);
    if (o_ms !== '0 && o_ms !== 'x) begin
      seen_start = 1;
      start_cyc  = cyc;
      if (gnt_q.size() == 0) chk("unexpected_grant", {26'd0, o_ms}, 32'd0);
      else begin
        g = gnt_q.pop_front();
        chk("grant_onehot", {26'd0, o_ms}, 32'(N'(1) << g));
      end
    end
    if (o_wr === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {16'd0, o_data}, 32'hdead);
      else begin
        e = exp_q.pop_front();
        chk("write_kind", {31'd0, e.is_end}, 32'd0);
        chk("tx_data", {16'd0, o_data}, {16'd0, e.data});
        chk("rd_req", {26'd0, o_rd}, {26'd0, e.rd});
        if (e.is_hdr) begin
          hdr_cyc = cyc;
          chk("grant_id_vs_hdr", {24'd0, 4'd0, o_gid}, {24'd0, e.data[15:8]});
        end
      end
    end
    if (o_pk === 1'b1) begin
      end_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_pktend", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("pktend_expected", {31'd0, e.is_end}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (o_ms[s] === 1'b1) begin
        pend[s]--; widx[s] = 0; mno[s]++;
      end else if (o_rd[s] === 1'b1) begin
        widx[s]++;
      end
    end
    drive_buses();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_grant(string tag);
    int n = 0;
    seen_start = 0;
    while (!seen_start && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, seen_start}, 32'd1);
  endtask

  task automatic run_until_done(string tag);
    int n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size() + gnt_q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_wr"},     {31'd0, o_wr},   32'd0);
    chk({tag, "_rd"},     {26'd0, o_rd},   32'd0);
    chk({tag, "_ms"},     {26'd0, o_ms},   32'd0);
    chk({tag, "_data"},   {16'd0, o_data}, 32'd0);
    chk({tag, "_pktend"}, {31'd0, o_pk},   32'd0);
    chk({tag, "_busy"},   {31'd0, o_busy}, 32'd0);
    chk({tag, "_gid"},    {28'd0, o_gid},  32'd0);
  endtask

  initial begin
    rst = 1'b1; flag_full = 1'b1; hold = 1'b0;
    got_full_msg = '0; msg_len_bus = '0; fifo_q_bus = '0;
    model_clear();
    reset_dut();

    // reset state
    tick();
    chk_idle_outputs("reset");

    // single source, len 3: six cycles from grant to PKTEND
    load(2, 3);
    wait_grant("t1_grant");
    run_until_done("t1_done");
    chk("t1_cycles", 32'(end_cyc - start_cyc + 1), 32'd6);
    chk("t1_busy_pay", {31'd0, dut.busy}, 32'd0);
    chk("t1_grant_id_held", {28'd0, grant_id}, 32'd2);

    // round-robin from reset: 0, 1, 4, 0
    reset_dut();
    load(0, 1);
    load(1, 2);
    load(4, 1);
    load(0, 1);
    run_until_done("t2_done");

    // zero-length message on source 5
    load(5, 0);
    run_until_done("t3_done");
    chk("t3_hdr_to_pktend", 32'(end_cyc - hdr_cyc), 32'd1);

    // flag_full low for four cycles on the second payload word
    load(1, 4);
    wait_grant("t4_grant");
    tick();
    tick();
    flag_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_stall_wr", {31'd0, o_wr}, 32'd0);
      chk("t4_stall_rd", {26'd0, o_rd}, 32'd0);
      chk("t4_stall_data", {16'd0, o_data}, {16'd0, pw(1, issued[1], 1)});
      chk("t4_stall_busy", {31'd0, o_busy}, 32'd1);
    end
    flag_full = 1'b1;
    run_until_done("t4_done");

    // hold blocks grants but not a message already in flight
    hold = 1'b1;
    load(3, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_ms", {26'd0, o_ms}, 32'd0);
      chk("t5_hold_busy", {31'd0, o_busy}, 32'd0);
    end
    hold = 1'b0;
    wait_grant("t5_grant");
    tick();
    tick();
    hold = 1'b1;
    run_until_done("t5_done");
    hold = 1'b0;

    // reset mid-payload: abort, then arbitration restarts from source 0
    load(4, 6);
    wait_grant("t6_grant");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    gnt_q.delete();
    tick();
    chk_idle_outputs("t6_after_rst");
    load(1, 2);
    load(5, 1);
    run_until_done("t6_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
